// File: rtl/sdm_filter_sequencer_if.sv
// Arbitrated output stream of the sinc3 filter sequencer: one 16-bit word
// tagged with its source channel, valid/ready handshake.
interface sdm_filter_sequencer_if #(
  parameter int CH_W = 3
);
  logic [15:0]     out_data;
  logic [CH_W-1:0] out_ch;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sdm_filter_sequencer.sv
// Sequencer for a bank of N sinc3 decimators sharing mclk1: group reset,
// start-up word discard, per-channel word buffering and a round-robin merge
// of all channels into one channel-tagged valid/ready stream.
module sdm_filter_sequencer #(
  parameter int N            = 4,
  parameter int RST_CYCLES   = 4,
  parameter int SETTLE_WORDS = 3,
  parameter int CH_W         = 3
) (
  input  logic                   mclk1,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [N-1:0]           ch_enable,
  input  logic [16*N-1:0]        filt_data,
  input  logic [N-1:0]           filt_data_en,
  output logic [N-1:0]           filt_reset,
  output logic [N-1:0]           overrun,
  input  logic                   clear_overrun,
  output logic [1:0]             state,
  output logic                   busy,
  sdm_filter_sequencer_if.master out_if
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SCW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_filt_reset;
  logic [N-1:0]    r_en_q;
  logic [RCW-1:0]  r_rst_cnt;
  logic [SCW-1:0]  r_settle_cnt [N];
  logic [15:0]     r_hold [N];
  logic [N-1:0]    r_pending;
  logic [N-1:0]    r_overrun;
  logic [CH_W-1:0] r_ptr;
  logic [15:0]     r_out_data;
  logic [CH_W-1:0] r_out_ch;
  logic            r_out_valid;

  logic            w_stop_acc;
  logic            w_settle_done;
  logic [N-1:0]    w_cap;
  logic [N-1:0]    w_req;
  logic            w_load;
  logic            w_found;
  logic [CH_W-1:0] w_win;
  logic [CH_W-1:0] w_ptr_next;
  logic [15:0]     w_win_data;
  logic [N-1:0]    w_grant;

  // A stop pulse is honoured in every active state; it also suppresses
  // captures and grants in that cycle so that pending work is simply dropped.
  assign w_stop_acc = stop & (r_state != ST_IDLE);
  assign w_cap      = filt_data_en & r_en_q &
                      {N{(r_state == ST_RUN) & ~w_stop_acc}};
  assign w_req      = r_pending & {N{~w_stop_acc}};
  assign w_load     = ~r_out_valid | out_if.out_ready;
  assign w_grant    = (w_load && w_found) ? (N'(1) << w_win) : '0;

  // Settling is complete once every enabled channel has seen enough words.
  always_comb begin
    w_settle_done = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (r_en_q[k] && (r_settle_cnt[k] != SETTLE_MAX)) w_settle_done = 1'b0;
    end
  end

  // Round-robin search for the first pending channel at or after the pointer.
  always_comb begin : p_arb
    int v_idx;
    w_found    = 1'b0;
    w_win      = '0;
    w_ptr_next = '0;
    w_win_data = '0;
    v_idx      = 0;
    for (int i = 0; i < N; i++) begin
      v_idx = (int'(r_ptr) + i) % N;
      if (!w_found && w_req[v_idx]) begin
        w_found    = 1'b1;
        w_win      = CH_W'(v_idx);
        w_ptr_next = CH_W'((v_idx + 1) % N);
        w_win_data = r_hold[v_idx];
      end
    end
  end

  // Sequencer FSM; filt_reset is registered alongside the state it belongs to.
  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_filt_reset <= '1;
      r_en_q       <= '0;
      r_rst_cnt    <= '0;
    end else if (w_stop_acc) begin
      r_state      <= ST_IDLE;
      r_filt_reset <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && (|ch_enable)) begin
            r_en_q    <= ch_enable;
            r_rst_cnt <= '0;
            r_state   <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state      <= ST_SETTLE;
            r_filt_reset <= ~r_en_q;
          end else begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
          end
        end
        ST_SETTLE: begin
          if (w_settle_done) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_filt_reset <= '1;
        end
      endcase
    end
  end

  // Per-channel saturating count of start-up words; held at zero outside SETTLE.
  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) r_settle_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if ((r_state != ST_SETTLE) || w_stop_acc) begin
          r_settle_cnt[k] <= '0;
        end else if (filt_data_en[k] && r_en_q[k] && (r_settle_cnt[k] != SETTLE_MAX)) begin
          r_settle_cnt[k] <= r_settle_cnt[k] + SCW'(1);
        end
      end
    end
  end

  // Hold buffers, pending/overrun flags and the output register with pointer.
  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) r_hold[k] <= '0;
      r_pending   <= '0;
      r_overrun   <= '0;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_cap[k]) r_hold[k] <= filt_data[16*k +: 16];
      end
      // A granted channel may capture a fresh word in the same cycle without
      // counting as an overrun: the old word leaves as the new one lands.
      r_pending <= w_stop_acc ? '0 : (w_cap | (r_pending & ~w_grant));
      r_overrun <= (w_cap & r_pending & ~w_grant) |
                   (r_overrun & {N{~clear_overrun}});
      if (w_load) begin
        if (w_found) begin
          r_out_data  <= w_win_data;
          r_out_ch    <= w_win;
          r_out_valid <= 1'b1;
          r_ptr       <= w_ptr_next;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign filt_reset       = r_filt_reset;
  assign overrun          = r_overrun;
  assign state            = r_state;
  assign busy             = (r_state != ST_IDLE);
  assign out_if.out_data  = r_out_data;
  assign out_if.out_ch    = r_out_ch;
  assign out_if.out_valid = r_out_valid;

endmodule

// File: tb/tb_sdm_filter_sequencer.sv
// Bench for sdm_filter_sequencer: table of single-word transfers plus
// hand-written sequences for start-up, round-robin, backpressure/overrun,
// stop and asynchronous reset; a scoreboard checks every output handshake.
module tb_sdm_filter_sequencer;

  localparam int N            = 4;
  localparam int RST_CYCLES   = 4;
  localparam int SETTLE_WORDS = 3;
  localparam int CH_W         = 3;

  logic            mclk1;
  logic            reset_n;
  logic            start;
  logic            stop;
  logic [N-1:0]    ch_enable;
  logic [16*N-1:0] filt_data;
  logic [N-1:0]    filt_data_en;
  logic [N-1:0]    filt_reset;
  logic [N-1:0]    overrun;
  logic            clear_overrun;
  logic [1:0]      state;
  logic            busy;

  sdm_filter_sequencer_if #(.CH_W(CH_W)) bus ();

  sdm_filter_sequencer #(
    .N(N), .RST_CYCLES(RST_CYCLES), .SETTLE_WORDS(SETTLE_WORDS), .CH_W(CH_W)
  ) dut (
    .mclk1(mclk1), .reset_n(reset_n), .start(start), .stop(stop),
    .ch_enable(ch_enable), .filt_data(filt_data), .filt_data_en(filt_data_en),
    .filt_reset(filt_reset), .overrun(overrun), .clear_overrun(clear_overrun),
    .state(state), .busy(busy), .out_if(bus)
  );

  typedef struct {
    logic [1:0]      ch;
    logic [15:0]     data;
    logic [CH_W-1:0] exp_ch;
    logic [15:0]     exp_data;
  } vec_t;

  typedef struct {
    logic [15:0]     data;
    logic [CH_W-1:0] ch;
  } sb_t;

  vec_t vecs [6];
  sb_t  sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial mclk1 = 1'b0;
  always #5 mclk1 = ~mclk1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk1);
    #1;
  endtask

  task automatic set_word(input int k, input logic [15:0] v);
    filt_data[16*k +: 16] = v;
  endtask

  task automatic push(input logic [15:0] d, input int ch);
    sb_t e;
    e.data = d;
    e.ch   = CH_W'(ch);
    sb.push_back(e);
  endtask

  task automatic bring_up(input logic [N-1:0] mask);
    ch_enable = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES) tick();
    chk("bu_settle", state, 2);
    for (int i = 0; i < SETTLE_WORDS; i++) begin
      filt_data_en = mask;
      tick();
      filt_data_en = '0;
      tick();
    end
    chk("bu_run", state, 3);
  endtask

  // Scoreboard: every accepted output word must match the oldest expectation.
  always @(negedge mclk1) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", {bus.out_ch, bus.out_data}, 64'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_ch", bus.out_ch, e.ch);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ch: 2'd0, data: 16'h0000, exp_ch: 3'd0, exp_data: 16'h0000};
    vecs[1] = '{ch: 2'd1, data: 16'hFFFF, exp_ch: 3'd1, exp_data: 16'hFFFF};
    vecs[2] = '{ch: 2'd2, data: 16'h8000, exp_ch: 3'd2, exp_data: 16'h8000};
    vecs[3] = '{ch: 2'd3, data: 16'h7FFF, exp_ch: 3'd3, exp_data: 16'h7FFF};
    vecs[4] = '{ch: 2'd2, data: 16'h5A5A, exp_ch: 3'd2, exp_data: 16'h5A5A};
    vecs[5] = '{ch: 2'd3, data: 16'h1357, exp_ch: 3'd3, exp_data: 16'h1357};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; ch_enable = '0;
    filt_data = '0; filt_data_en = '0; clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_filt_reset", filt_reset, 4'hF);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ch", bus.out_ch, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Normal start-up with channels 0 and 2
    ch_enable = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    ch_enable = '0;
    chk("su_state_reset", state, 1);
    chk("su_busy", busy, 1);
    chk("su_frst_first", filt_reset, 4'hF);
    for (int i = 1; i < RST_CYCLES; i++) begin
      tick();
      chk("su_frst_hold", filt_reset, 4'hF);
      chk("su_state_hold", state, 1);
    end
    tick();
    chk("su_state_settle", state, 2);
    chk("su_frst_settle", filt_reset, 4'b1010);
    for (int i = 0; i < SETTLE_WORDS; i++) begin
      for (int k = 0; k < N; k++) set_word(k, 16'hDEAD);
      filt_data_en = 4'b0111;
      tick();
      filt_data_en = '0;
      chk("su_still_settle", state, 2);
      tick();
      chk("su_settle_to_run", state, (i == SETTLE_WORDS - 1) ? 2'd3 : 2'd2);
    end
    chk("su_no_settle_words", bus.out_valid, 0);
    set_word(0, 16'h1234);
    push(16'h1234, 0);
    filt_data_en = 4'b0001;
    tick();
    filt_data_en = '0;
    chk("lat_not_yet", bus.out_valid, 0);
    tick();
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 16'h1234);
    chk("lat_ch", bus.out_ch, 0);
    tick();
    chk("lat_drain", bus.out_valid, 0);
    set_word(1, 16'hBEEF);
    filt_data_en = 4'b0010;
    tick();
    filt_data_en = '0;
    repeat (2) tick();
    chk("disabled_ch_ignored", bus.out_valid, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("su_stop_state", state, 0);
    chk("su_stop_frst", filt_reset, 4'hF);
    chk("su_stop_busy", busy, 0);

    // Table of single-word transfers, all channels enabled
    bring_up(4'hF);
    for (int v = 0; v < 6; v++) begin
      set_word(int'(vecs[v].ch), vecs[v].data);
      push(vecs[v].exp_data, int'(vecs[v].exp_ch));
      filt_data_en = 4'b0001 << vecs[v].ch;
      tick();
      filt_data_en = '0;
      chk("vec_capture_only", bus.out_valid, 0);
      tick();
      chk("vec_valid", bus.out_valid, 1);
      chk("vec_data", bus.out_data, vecs[v].exp_data);
      chk("vec_ch", bus.out_ch, vecs[v].exp_ch);
      tick();
      chk("vec_drain", bus.out_valid, 0);
    end

    // start outside IDLE is ignored
    ch_enable = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    ch_enable = '0;
    chk("start_in_run_ignored", state, 3);

    // Round-robin bursts; pointer is at 0 after the last table entry (ch3)
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        set_word(k, (b == 0 ? 16'hA000 : 16'hB000) + 16'(k));
        push((b == 0 ? 16'hA000 : 16'hB000) + 16'(k), k);
      end
      filt_data_en = 4'hF;
      tick();
      filt_data_en = '0;
      for (int k = 0; k < N; k++) begin
        tick();
        chk("rr_valid", bus.out_valid, 1);
        chk("rr_ch", bus.out_ch, k);
        chk("rr_data", bus.out_data, (b == 0 ? 16'hA000 : 16'hB000) + 16'(k));
      end
      tick();
      chk("rr_drain", bus.out_valid, 0);
    end

    // Backpressure: grant plus capture, then a real overrun
    bus.out_ready = 1'b0;
    set_word(1, 16'h0001);
    filt_data_en = 4'b0010;
    tick();
    set_word(1, 16'h0002);
    tick();
    filt_data_en = '0;
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 16'h0001);
    chk("bp_ch", bus.out_ch, 1);
    chk("bp_no_overrun", overrun, 0);
    tick();
    chk("bp_stable", bus.out_data, 16'h0001);
    set_word(1, 16'h0003);
    filt_data_en = 4'b0010;
    tick();
    filt_data_en = '0;
    chk("ovr_set", overrun, 4'b0010);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_clear", overrun, 0);
    push(16'h0001, 1);
    push(16'h0003, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_newest_word", bus.out_data, 16'h0003);
    chk("bp_newest_valid", bus.out_valid, 1);
    tick();
    chk("bp_drain", bus.out_valid, 0);

    // Overrun set and clear in the same cycle: set wins
    bus.out_ready = 1'b0;
    set_word(2, 16'hC001);
    filt_data_en = 4'b0100;
    tick();
    set_word(2, 16'hC002);
    tick();
    set_word(2, 16'hC003);
    clear_overrun = 1'b1;
    tick();
    filt_data_en = '0;
    clear_overrun = 1'b0;
    chk("ovr_set_wins", overrun, 4'b0100);
    tick();
    chk("ovr_sticky", overrun, 4'b0100);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_clear2", overrun, 0);
    push(16'hC001, 2);
    push(16'hC003, 2);
    bus.out_ready = 1'b1;
    tick();
    chk("ovr2_word", bus.out_data, 16'hC003);
    tick();
    chk("ovr2_drain", bus.out_valid, 0);

    // Stop mid-RUN with a held output word and pending words
    bus.out_ready = 1'b0;
    set_word(0, 16'hD000);
    filt_data_en = 4'b0001;
    tick();
    filt_data_en = '0;
    tick();
    set_word(1, 16'hD001);
    set_word(3, 16'hD003);
    filt_data_en = 4'b1010;
    tick();
    filt_data_en = '0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_frst", filt_reset, 4'hF);
    chk("stop_busy", busy, 0);
    chk("stop_valid_kept", bus.out_valid, 1);
    chk("stop_data_kept", bus.out_data, 16'hD000);
    repeat (3) tick();
    chk("stop_valid_idle", bus.out_valid, 1);
    push(16'hD000, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("stop_drop", bus.out_valid, 0);
    tick();
    chk("stop_pending_cleared", bus.out_valid, 0);
    chk("stop_overrun_kept_zero", overrun, 0);

    // Asynchronous reset during SETTLE with a word still held in the output
    bring_up(4'hF);
    bus.out_ready = 1'b0;
    set_word(2, 16'hE002);
    filt_data_en = 4'b0100;
    tick();
    filt_data_en = '0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ch_enable = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES) tick();
    chk("ar_in_settle", state, 2);
    chk("ar_held_word", bus.out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_data", bus.out_data, 0);
    chk("ar_frst", filt_reset, 4'hF);
    chk("ar_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    ch_enable = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_mask_state", state, 0);
    chk("zero_mask_busy", busy, 0);
    tick();
    chk("zero_mask_state2", state, 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdm_filter_sequencer.md
Name: sdm_filter_sequencer

Overview:
Controls a bank of N sinc3 decimation filters that share the modulator clock mclk1. It resets and restarts the filters as a group, discards the start-up words while the filters settle, and buffers each channel's output word. A round-robin arbiter then merges the channels into one valid/ready stream tagged with the channel number. It sits between the per-channel filters and the downstream packetiser/register block.

Parameters:
N, 4, number of filter channels (1..8)
RST_CYCLES, 4, mclk1 cycles that filt_reset is held high on entry to RESET (>=1)
SETTLE_WORDS, 3, filter output words discarded per channel after reset (>=0)
CH_W, 3, width of out_ch (must satisfy 2^CH_W >= N)

Ports:
mclk1  in  1  block clock, same clock as the filters
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; accepted only in IDLE
stop  in  1  single-cycle pulse; accepted in any state except IDLE
ch_enable  in  N  channel enable mask, sampled when start is accepted
filt_data  in  16*N  filter words; channel k uses bits [16k+15:16k]
filt_data_en  in  N  per-channel single-cycle word-valid strobe
filt_reset  out  N  per-channel filter reset, active high
out_data  out  16  arbitrated word
out_ch  out  CH_W  source channel of out_data
out_valid  out  1  out_data/out_ch are valid
out_ready  in  1  downstream accepts the word
overrun  out  N  sticky flag: a channel word was overwritten before it was drained
clear_overrun  in  1  clears all overrun bits
state  out  2  0=IDLE, 1=RESET, 2=SETTLE, 3=RUN
busy  out  1  asserted whenever state != IDLE

Behaviour:
- Reset (reset_n=0), applied asynchronously:
  - state=IDLE, filt_reset=all 1s, out_valid=0, out_data=0, out_ch=0, overrun=0, busy=0.
  - All hold registers, pending bits, settle counters and the round-robin pointer are cleared; the pointer resets to 0.
- IDLE:
  - filt_reset is all 1s.
  - start with ch_enable!=0: latch ch_enable into en_q and go to RESET.
  - start with ch_enable==0: ignored, stay in IDLE.
- RESET:
  - filt_reset=all 1s for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - filt_reset[k]=~en_q[k].
  - Each enabled channel counts its filt_data_en pulses with a saturating counter.
  - When every enabled channel's counter reaches SETTLE_WORDS, go to RUN. With SETTLE_WORDS=0, go to RUN the cycle after entering SETTLE.
  - Words arriving in SETTLE are never captured.
- RUN:
  - filt_reset[k]=~en_q[k].
  - filt_data_en[k] with en_q[k]=1 captures the word into hold[k] on the next edge and sets pending[k].
  - filt_data_en on a disabled channel is ignored in every state.
- stop (RESET, SETTLE or RUN):
  - Go to IDLE next cycle.
  - Clear pending and the settle counters; filt_reset returns to all 1s.
  - A word already in the output register is kept until out_ready handshakes it; out_valid may remain 1 in IDLE.
- start arriving outside IDLE is ignored.
- Output register:
  - Loaded when out_valid==0, or when out_valid & out_ready.
  - The winner is the first channel with pending set, searching from the pointer upward and wrapping modulo N.
  - On load: out_data=hold[w], out_ch=w, out_valid=1, pending[w] cleared, pointer=(w+1) mod N.
  - If nothing is pending when the handshake completes, out_valid drops to 0.
  - out_data and out_ch stay stable while out_valid & ~out_ready.
- Latency: filt_data_en at edge t gives out_valid at edge t+2 when there is no contention and the output register is free.
- Simultaneous events on one channel:
  - Grant and new capture in the same cycle: the grant takes the old word, the new word is captured, pending stays 1, no overrun.
  - Capture while pending=1 and not granted: hold is overwritten with the newer word and overrun[k] is set.
- overrun:
  - Cleared by clear_overrun.
  - If clear_overrun and a new overrun occur in the same cycle, the set wins.
  - Not cleared by start or stop.
- busy=(state!=IDLE).

Test Plan:
- Normal start-up (N=4, RST_CYCLES=4, SETTLE_WORDS=3, ch_enable=4'b0101): pulse start -> filt_reset=4'b1111 for 4 cycles, then 4'b1010; state moves to RUN after the 3rd strobe on both ch0 and ch2; a 4th strobe on ch0 with data 16'h1234 gives out_valid two cycles later with out_data=16'h1234, out_ch=0.
- Round-robin: all 4 channels enabled, RUN, same-cycle strobes with data 16'hA000..16'hA003, out_ready=1 -> outputs appear in channel order 0,1,2,3 on consecutive cycles; a second same-cycle burst starts from channel 0 again because the pointer has wrapped to 0.
- Backpressure and overrun: out_ready=0, ch1 strobes 16'h0001 and then 16'h0002 -> out_valid=1 holding 16'h0001; hold[1]=16'h0002, pending[1]=1, overrun[1]=0. A third strobe 16'h0003 with out_ready still 0 -> overrun=4'b0010 and hold[1]=16'h0003. clear_overrun -> overrun=0.
- Stop mid-RUN: stop while words are pending and out_valid=1, out_ready=0 -> state=IDLE next cycle, filt_reset=4'b1111, pending cleared, out_valid stays 1 until out_ready, then drops to 0.
- Async reset mid-SETTLE: assert reset_n=0 between clock edges -> state=IDLE, out_valid=0 and filt_reset=4'b1111 immediately; start with ch_enable=0 afterwards -> stays in IDLE, busy=0.
